// File: rtl/fpro_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fpro_bus_arbiter_if
// Purpose  : Signal bundle for the two-master FPro arbiter (masters + FPro bus)
// Revision : 1.0 - initial release
// ============================================================================
interface fpro_bus_arbiter_if;
  logic        m0_video_cs;
  logic        m0_mmio_cs;
  logic        m0_wr;
  logic        m0_rd;
  logic [20:0] m0_addr;
  logic [31:0] m0_wr_data;
  logic [31:0] m0_rd_data;
  logic        m0_ready;

  logic        m1_video_cs;
  logic        m1_mmio_cs;
  logic        m1_wr;
  logic        m1_rd;
  logic [20:0] m1_addr;
  logic [31:0] m1_wr_data;
  logic [31:0] m1_rd_data;
  logic        m1_ready;

  logic        fp_video_cs;
  logic        fp_mmio_cs;
  logic        fp_wr;
  logic        fp_rd;
  logic [20:0] fp_addr;
  logic [31:0] fp_wr_data;
  logic [31:0] fp_rd_data;

  logic        arb_ovr;

  modport slave (
    input  m0_video_cs, m0_mmio_cs, m0_wr, m0_rd, m0_addr, m0_wr_data,
    output m0_rd_data, m0_ready,
    input  m1_video_cs, m1_mmio_cs, m1_wr, m1_rd, m1_addr, m1_wr_data,
    output m1_rd_data, m1_ready,
    output fp_video_cs, fp_mmio_cs, fp_wr, fp_rd, fp_addr, fp_wr_data,
    input  fp_rd_data,
    output arb_ovr
  );

  modport master (
    output m0_video_cs, m0_mmio_cs, m0_wr, m0_rd, m0_addr, m0_wr_data,
    input  m0_rd_data, m0_ready,
    output m1_video_cs, m1_mmio_cs, m1_wr, m1_rd, m1_addr, m1_wr_data,
    input  m1_rd_data, m1_ready,
    input  fp_video_cs, fp_mmio_cs, fp_wr, fp_rd, fp_addr, fp_wr_data,
    output fp_rd_data,
    input  arb_ovr
  );
endinterface
`default_nettype wire

// File: rtl/fpro_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpro_bus_arbiter
// Purpose  : Two-master FPro bus arbiter; FPRO_ARB_RR_EN selects round-robin,
//            otherwise master 0 wins ties.
// Revision : 1.0 - initial release
// ============================================================================
module fpro_bus_arbiter (
  input  logic               clk,
  input  logic               reset,
  fpro_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ISSUED = 2'd2
  } state_t;

  state_t r_state     [2];
  state_t w_state_nxt [2];

  logic [1:0]        w_wr, w_rd, w_vcs, w_mcs;
  logic [1:0][20:0]  w_addr;
  logic [1:0][31:0]  w_wdata;

  logic [1:0]        r_h_wr, r_h_rd, r_h_vcs, r_h_mcs;
  logic [1:0][20:0]  r_h_addr;
  logic [1:0][31:0]  r_h_wdata;

  logic [1:0]        w_s_wr, w_s_rd, w_s_vcs, w_s_mcs;
  logic [1:0][20:0]  w_s_addr;
  logic [1:0][31:0]  w_s_wdata;

  logic [1:0]        w_req, w_idle, w_accept, w_drop, w_cand, w_grant;
  logic              w_win;
  logic              r_prio;

  logic              r_fp_vcs, r_fp_mcs, r_fp_wr, r_fp_rd;
  logic [20:0]       r_fp_addr;
  logic [31:0]       r_fp_wdata;
  logic [1:0]        r_ready;
  logic [1:0][31:0]  r_rd_data;
  logic              r_ovr;

  assign w_wr    = {bus.m1_wr, bus.m0_wr};
  assign w_rd    = {bus.m1_rd, bus.m0_rd};
  assign w_vcs   = {bus.m1_video_cs, bus.m0_video_cs};
  assign w_mcs   = {bus.m1_mmio_cs, bus.m0_mmio_cs};
  assign w_addr  = {bus.m1_addr, bus.m0_addr};
  assign w_wdata = {bus.m1_wr_data, bus.m0_wr_data};

  // An idle master presents its live strobe (holding bypass); a waiting one its latched request.
  genvar k;
  generate
    for (k = 0; k < 2; k++) begin : g_master
      assign w_req[k]     = w_wr[k] | w_rd[k];
      assign w_idle[k]    = (r_state[k] == S_IDLE);
      assign w_accept[k]  = w_req[k] & w_idle[k];
      assign w_drop[k]    = w_req[k] & ~w_idle[k];
      assign w_cand[k]    = w_accept[k] | (r_state[k] == S_WAIT);
      assign w_s_wr[k]    = w_idle[k] ? w_wr[k]               : r_h_wr[k];
      assign w_s_rd[k]    = w_idle[k] ? (w_rd[k] & ~w_wr[k])  : r_h_rd[k];
      assign w_s_vcs[k]   = w_idle[k] ? w_vcs[k]              : r_h_vcs[k];
      assign w_s_mcs[k]   = w_idle[k] ? w_mcs[k]              : r_h_mcs[k];
      assign w_s_addr[k]  = w_idle[k] ? w_addr[k]             : r_h_addr[k];
      assign w_s_wdata[k] = w_idle[k] ? w_wdata[k]            : r_h_wdata[k];
    end
  endgenerate

  always_comb begin
    w_grant = w_cand;
    if (w_cand == 2'b11) begin
      w_grant = r_prio ? 2'b10 : 2'b01;
    end
  end

  assign w_win = w_grant[1];

  always_comb begin
    for (int m = 0; m < 2; m++) begin
      w_state_nxt[m] = r_state[m];
      case (r_state[m])
        S_IDLE:   if (w_accept[m]) w_state_nxt[m] = w_grant[m] ? S_ISSUED : S_WAIT;
        S_WAIT:   if (w_grant[m])  w_state_nxt[m] = S_ISSUED;
        S_ISSUED: w_state_nxt[m] = S_IDLE;
        default:  w_state_nxt[m] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state[0] <= S_IDLE;
      r_state[1] <= S_IDLE;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_wr     <= '0;
      r_h_rd     <= '0;
      r_h_vcs    <= '0;
      r_h_mcs    <= '0;
      r_h_addr   <= '0;
      r_h_wdata  <= '0;
      r_prio     <= 1'b0;
      r_fp_vcs   <= 1'b0;
      r_fp_mcs   <= 1'b0;
      r_fp_wr    <= 1'b0;
      r_fp_rd    <= 1'b0;
      r_fp_addr  <= '0;
      r_fp_wdata <= '0;
      r_ready    <= '0;
      r_rd_data  <= '0;
      r_ovr      <= 1'b0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (w_accept[m]) begin
          r_h_wr[m]    <= w_wr[m];
          r_h_rd[m]    <= w_rd[m] & ~w_wr[m];
          r_h_vcs[m]   <= w_vcs[m];
          r_h_mcs[m]   <= w_mcs[m];
          r_h_addr[m]  <= w_addr[m];
          r_h_wdata[m] <= w_wdata[m];
        end
        r_ready[m] <= (r_state[m] == S_ISSUED);
        // The bus read belongs to whichever master is in ISSUED; chip-select misses read as zero.
        if ((r_state[m] == S_ISSUED) && r_fp_rd) begin
          r_rd_data[m] <= (r_fp_vcs | r_fp_mcs) ? bus.fp_rd_data : 32'd0;
        end
      end

      if (|w_drop) begin
        r_ovr <= 1'b1;
      end

      r_fp_wr  <= (|w_grant) & w_s_wr[w_win];
      r_fp_rd  <= (|w_grant) & w_s_rd[w_win];
      r_fp_vcs <= (|w_grant) & w_s_vcs[w_win];
      r_fp_mcs <= (|w_grant) & w_s_mcs[w_win];
      if (|w_grant) begin
        r_fp_addr  <= w_s_addr[w_win];
        r_fp_wdata <= w_s_wdata[w_win];
`ifdef FPRO_ARB_RR_EN
        r_prio     <= ~w_win;
`endif
      end
    end
  end

  assign bus.fp_video_cs = r_fp_vcs;
  assign bus.fp_mmio_cs  = r_fp_mcs;
  assign bus.fp_wr       = r_fp_wr;
  assign bus.fp_rd       = r_fp_rd;
  assign bus.fp_addr     = r_fp_addr;
  assign bus.fp_wr_data  = r_fp_wdata;
  assign bus.m0_ready    = r_ready[0];
  assign bus.m1_ready    = r_ready[1];
  assign bus.m0_rd_data  = r_rd_data[0];
  assign bus.m1_rd_data  = r_rd_data[1];
  assign bus.arb_ovr     = r_ovr;

endmodule
`default_nettype wire
